// File: rtl/cordic_floatingpoint_addsub_align_pkg.sv
// cordic_floatingpoint_addsub_align_pkg: shared widths for the FP add/sub alignment stage.
package cordic_floatingpoint_addsub_align_pkg;
    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;
    localparam int GRS_W     = 3;
endpackage

// File: rtl/cordic_floatingpoint_addsub_rshift_sticky.sv
// cordic_floatingpoint_addsub_rshift_sticky: log-depth right shifter folding lost bits into bit 0.
module cordic_floatingpoint_addsub_rshift_sticky
    import cordic_floatingpoint_addsub_align_pkg::*;
#(
    parameter int W    = 28,
    parameter int SH_W = 8
) (
    input  logic [W-1:0]    in_i,
    input  logic [SH_W-1:0] sh_i,
    output logic [W-1:0]    out_o
);
    localparam int L = $clog2(W);
    logic [W-1:0] st [L+1];
    logic         sk [L+1];
    assign st[0] = in_i;
    assign sk[0] = 1'b0;
    for (genvar k = 0; k < L; k++) begin : g_stage
        localparam logic [W-1:0] LOST = (W'(1) << (1 << k)) - W'(1);
        assign st[k+1] = sh_i[k] ? st[k] >> (1 << k) : st[k];
        assign sk[k+1] = sk[k] | (sh_i[k] & |(st[k] & LOST));
    end
    // Any shift past the upper stages flushes everything into the sticky bit.
    assign out_o = |sh_i[SH_W-1:L] ? {{(W-1){1'b0}}, |in_i} : {st[L][W-1:1], st[L][0] | sk[L]};
endmodule

// File: rtl/cordic_floatingpoint_addsub_align.sv
// cordic_floatingpoint_addsub_align: two-stage operand order/align/complement ahead of the CLA chain.
module cordic_floatingpoint_addsub_align
    import cordic_floatingpoint_addsub_align_pkg::*;
#(
    parameter  int EXP_W   = EXP_W_DEF,
    parameter  int MAN_W   = MAN_W_DEF,
    localparam int W       = 1 + EXP_W + MAN_W,
    localparam int ALIGN_W = MAN_W + 2 + GRS_W
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               iValid,
    output logic               oReady,
    input  logic [W-1:0]       iA,
    input  logic [W-1:0]       iB,
    input  logic               iSub,
    output logic               oValid,
    input  logic               iReady,
    output logic [ALIGN_W-1:0] oMa,
    output logic [ALIGN_W-1:0] oMb,
    output logic               oCin,
    output logic               oEffSub,
    output logic [EXP_W-1:0]   oExp,
    output logic               oSign,
    output logic               oSwap
);
    logic               en1, en2, v1_q, v2_q;
    logic [EXP_W-1:0]   ea, eb, exp_l_d, d_d, exp_l_q, d_q, exp_q;
    logic [MAN_W:0]     ma, mb, man_l_d, man_s_d, man_l_q, man_s_q;
    logic               swap_d, sign_d, eff_d, sign1_q, eff1_q, swap1_q, sign_q, eff_q, swap_q;
    logic [ALIGN_W-1:0] sh_in, sh_out, ma_q, mb_q;
    assign ea = iA[W-2 -: EXP_W];
    assign eb = iB[W-2 -: EXP_W];
    // Zero exponent flushes to zero: no hidden bit and fraction discarded.
    assign ma = {|ea, |ea ? iA[MAN_W-1:0] : {MAN_W{1'b0}}};
    assign mb = {|eb, |eb ? iB[MAN_W-1:0] : {MAN_W{1'b0}}};
    assign swap_d  = {eb, mb} > {ea, ma};
    assign eff_d   = iA[W-1] ^ iB[W-1] ^ iSub;
    assign sign_d  = swap_d ? iB[W-1] ^ iSub : iA[W-1];
    assign exp_l_d = swap_d ? eb : ea;
    assign d_d     = exp_l_d - (swap_d ? ea : eb);
    assign man_l_d = swap_d ? mb : ma;
    assign man_s_d = swap_d ? ma : mb;
    assign en2    = ~v2_q | iReady;
    assign en1    = ~v1_q | en2;
    assign oReady = en1;
    assign sh_in  = {1'b0, man_s_q, {GRS_W{1'b0}}};
    cordic_floatingpoint_addsub_rshift_sticky #(.W(ALIGN_W), .SH_W(EXP_W)) u_shift (
        .in_i  (sh_in),
        .sh_i  (d_q),
        .out_o (sh_out)
    );
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            exp_l_q <= '0;
            d_q     <= '0;
            man_l_q <= '0;
            man_s_q <= '0;
            sign1_q <= 1'b0;
            eff1_q  <= 1'b0;
            swap1_q <= 1'b0;
            ma_q    <= '0;
            mb_q    <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            eff_q   <= 1'b0;
            swap_q  <= 1'b0;
        end else begin
            if (en1) v1_q <= iValid;
            if (en1 && iValid) begin
                exp_l_q <= exp_l_d;
                d_q     <= d_d;
                man_l_q <= man_l_d;
                man_s_q <= man_s_d;
                sign1_q <= sign_d;
                eff1_q  <= eff_d;
                swap1_q <= swap_d;
            end
            if (en2) v2_q <= v1_q;
            if (en2 && v1_q) begin
                ma_q   <= {1'b0, man_l_q, {GRS_W{1'b0}}};
                mb_q   <= eff1_q ? ~sh_out : sh_out;
                exp_q  <= exp_l_q;
                sign_q <= sign1_q;
                eff_q  <= eff1_q;
                swap_q <= swap1_q;
            end
        end
    end
    assign oValid  = v2_q;
    assign oMa     = ma_q;
    assign oMb     = mb_q;
    assign oCin    = eff_q;
    assign oEffSub = eff_q;
    assign oExp    = exp_q;
    assign oSign   = sign_q;
    assign oSwap   = swap_q;
endmodule
